// File: rtl/xsr.sv
// Serial receiver: synchronises rxd_i, finds the start edge, samples each bit at
// its centre and hands the assembled frame to the consumer over a valid/ack handshake.
module xsr #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rxd_i,
    input  logic [15:0] rxbaud_i,
    input  logic [5:0]  bits_i,
    input  logic        rxack_i,
    output logic [63:0] dat_o,
    output logic        rxvalid_o,
    output logic        framing_err_o,
    output logic        overrun_o,
    output logic        idle_o,
    output logic [5:0]  bits_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     rp_q;
    logic                     rs;
    logic                     start_edge;
    logic [15:0]              brg_q, brg_d;
    logic [15:0]              baud_q, baud_d;
    logic [5:0]               n_q, n_d;
    logic [5:0]               cnt_q, cnt_d;
    logic [63:0]              frame_q, frame_d;
    logic [63:0]              dat_q, dat_d;
    logic                     valid_q, valid_d;
    logic                     ferr_q, ferr_d;
    logic                     ovr_q, ovr_d;
    logic                     ack_taken;

    assign rs         = sync_q[SYNC_STAGES-1];
    assign start_edge = rp_q & ~rs;
    assign ack_taken  = rxack_i & valid_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d = state_q;
        brg_d   = brg_q;
        baud_d  = baud_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        dat_d   = dat_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (ack_taken) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_edge && bits_i != 6'd0) begin
                    baud_d  = rxbaud_i;
                    n_d     = bits_i;
                    brg_d   = rxbaud_i >> 1;
                    cnt_d   = 6'd0;
                    frame_d = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (brg_q != 16'd0) begin
                    brg_d = brg_q - 16'd1;
                end else if (rs) begin
                    // Line back high at mid start bit: a glitch, not a frame.
                    state_d = S_IDLE;
                end else begin
                    frame_d[0] = 1'b0;
                    cnt_d      = 6'd1;
                    brg_d      = baud_q;
                    state_d    = (n_q == 6'd1) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (brg_q != 16'd0) begin
                    brg_d = brg_q - 16'd1;
                end else begin
                    frame_d[cnt_q] = rs;
                    cnt_d          = cnt_q + 6'd1;
                    brg_d          = baud_q;
                    if (cnt_q == n_q - 6'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // A new frame overrides a same-cycle ack; an ack in this cycle also means no overrun.
                dat_d   = frame_q;
                valid_d = 1'b1;
                ferr_d  = ~frame_q[n_q - 6'd1];
                ovr_d   = ack_taken ? 1'b0 : (ovr_q | valid_q);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset_i) begin
            sync_q  <= '1;
            rp_q    <= 1'b1;
            state_q <= S_IDLE;
            brg_q   <= '0;
            baud_q  <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            // NOTE: the frame buffer is a plain register, not a RAM, so it is cleared with everything else.
            frame_q <= '0;
            dat_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd_i};
            rp_q    <= rs;
            state_q <= state_d;
            brg_q   <= brg_d;
            baud_q  <= baud_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            dat_q   <= dat_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dat_o         = dat_q;
    assign rxvalid_o     = valid_q;
    assign framing_err_o = ferr_q;
    assign overrun_o     = ovr_q;
    assign idle_o        = (state_q == S_IDLE);
    assign bits_o        = cnt_q;

endmodule

// File: tb/tb_xsr.sv
// Directed bench for xsr: frames are driven bit by bit on rxd_i and the received
// word and flags are compared against hand-encoded frame values.
module tb_xsr;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        rxd_i;
    logic [15:0] rxbaud_i;
    logic [5:0]  bits_i;
    logic        rxack_i;
    logic [63:0] dat_o;
    logic        rxvalid_o;
    logic        framing_err_o;
    logic        overrun_o;
    logic        idle_o;
    logic [5:0]  bits_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame images, bit k = k-th bit on the line (start bit in bit 0).
    localparam logic [63:0] F_55     = 64'h2AA;  // 0x55 8N1
    localparam logic [63:0] F_55_BAD = 64'h0AA;  // 0x55 with stop bit 0
    localparam logic [63:0] F_0F     = 64'h21E;  // 0x0F 8N1

    xsr #(.SYNC_STAGES(2)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .rxd_i         (rxd_i),
        .rxbaud_i      (rxbaud_i),
        .bits_i        (bits_i),
        .rxack_i       (rxack_i),
        .dat_o         (dat_o),
        .rxvalid_o     (rxvalid_o),
        .framing_err_o (framing_err_o),
        .overrun_o     (overrun_o),
        .idle_o        (idle_o),
        .bits_o        (bits_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Drives n bits of f, each held b+1 clocks, then returns the line to idle.
    task automatic send_frame(input logic [63:0] f, input int n, input int b);
        for (int k = 0; k < n; k++) begin
            rxd_i = f[k];
            step(b + 1);
        end
        rxd_i = 1'b1;
    endtask

    // Waits for the one-cycle DONE state (busy with bits_o == n), optionally
    // acking in that cycle, and leaves time just after the edge that commits it.
    task automatic wait_done(input string tag, input int n, input logic ack);
        bit found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!idle_o && bits_o == 6'(n)) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        check({tag, "_done_seen"}, 64'(found), 64'd1);
        if (found) begin
            rxack_i = ack;
            step(1);
            rxack_i = 1'b0;
        end
    endtask

    task automatic ack_pulse();
        rxack_i = 1'b1;
        step(1);
        rxack_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy;
        bit seen;

        reset_i  = 1'b1;
        rxd_i    = 1'b1;
        rxbaud_i = 16'd3;
        bits_i   = 6'd10;
        rxack_i  = 1'b0;
        step(3);
        reset_i = 1'b0;
        check("rst_dat",   dat_o,         64'h0);
        check("rst_valid", rxvalid_o,     64'h0);
        check("rst_ferr",  framing_err_o, 64'h0);
        check("rst_ovr",   overrun_o,     64'h0);
        check("rst_idle",  idle_o,        64'h1);
        check("rst_bits",  bits_o,        64'h0);
        step(4);

        // Test 1: clean 0x55 frame.
        send_frame(F_55, 10, 3);
        wait_done("t1", 10, 1'b0);
        check("t1_dat",   dat_o,         F_55);
        check("t1_valid", rxvalid_o,     64'h1);
        check("t1_ferr",  framing_err_o, 64'h0);
        check("t1_ovr",   overrun_o,     64'h0);
        ack_pulse();
        check("t1_ack_valid", rxvalid_o, 64'h0);
        step(4);

        // Test 2: one-clock glitch with a long bit period is a false start.
        rxbaud_i = 16'd7;
        rxd_i    = 1'b0;
        step(1);
        rxd_i = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!idle_o) seen = 1'b1;
            step(1);
        end
        check("t2_start_seen", 64'(seen), 64'h1);
        step(20);
        check("t2_idle",  idle_o,    64'h1);
        check("t2_valid", rxvalid_o, 64'h0);
        check("t2_dat",   dat_o,     F_55);

        // Test 3: bad stop bit, then ack clears the flags.
        rxbaud_i = 16'd3;
        send_frame(F_55_BAD, 10, 3);
        wait_done("t3", 10, 1'b0);
        check("t3_dat",   dat_o,         F_55_BAD);
        check("t3_valid", rxvalid_o,     64'h1);
        check("t3_ferr",  framing_err_o, 64'h1);
        ack_pulse();
        check("t3_ack_valid", rxvalid_o,     64'h0);
        check("t3_ack_ferr",  framing_err_o, 64'h0);
        ack_pulse();
        check("t3_idle_ack", rxvalid_o, 64'h0);
        step(4);

        // Test 4: overrun, then a frame acked in its own DONE cycle.
        send_frame(F_55, 10, 3);
        wait_done("t4a", 10, 1'b0);
        check("t4a_ovr", overrun_o, 64'h0);
        step(4);
        send_frame(F_0F, 10, 3);
        wait_done("t4b", 10, 1'b0);
        check("t4b_dat",   dat_o,         F_0F);
        check("t4b_valid", rxvalid_o,     64'h1);
        check("t4b_ovr",   overrun_o,     64'h1);
        check("t4b_ferr",  framing_err_o, 64'h0);
        step(4);
        send_frame(F_55, 10, 3);
        wait_done("t4c", 10, 1'b1);
        check("t4c_dat",   dat_o,     F_55);
        check("t4c_valid", rxvalid_o, 64'h1);
        check("t4c_ovr",   overrun_o, 64'h0);
        step(4);

        // Test 5: reset mid-frame, then a clean frame.
        fork
            send_frame(F_55, 10, 3);
            begin
                seen = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    if (!idle_o && bits_o == 6'd4) begin
                        seen = 1'b1;
                        break;
                    end
                    step(1);
                end
                check("t5_mid_seen", 64'(seen), 64'h1);
                reset_i = 1'b1;
                step(1);
                reset_i = 1'b0;
                check("t5_dat",   dat_o,         64'h0);
                check("t5_valid", rxvalid_o,     64'h0);
                check("t5_ferr",  framing_err_o, 64'h0);
                check("t5_ovr",   overrun_o,     64'h0);
                check("t5_idle",  idle_o,        64'h1);
                check("t5_bits",  bits_o,        64'h0);
            end
        join
        step(100);
        ack_pulse();
        step(2);
        send_frame(F_55, 10, 3);
        wait_done("t5b", 10, 1'b0);
        check("t5b_dat",  dat_o,         F_55);
        check("t5b_ferr", framing_err_o, 64'h0);
        check("t5b_ovr",  overrun_o,     64'h0);
        ack_pulse();
        step(4);

        // Test 6: receiver disabled.
        bits_i = 6'd0;
        busy   = 0;
        fork
            send_frame(F_55, 10, 3);
            for (int i = 0; i < 50; i++) begin
                if (!idle_o || rxvalid_o) busy++;
                step(1);
            end
        join
        check("t6_busy",  64'(busy), 64'h0);
        check("t6_valid", rxvalid_o, 64'h0);

        // rxbaud = 0: one clock per bit, line held low across the whole frame.
        rxbaud_i = 16'd0;
        bits_i   = 6'd4;
        rxd_i    = 1'b0;
        step(6);
        rxd_i = 1'b1;
        wait_done("b0", 4, 1'b0);
        check("b0_dat",   dat_o,         64'h0);
        check("b0_valid", rxvalid_o,     64'h1);
        check("b0_ferr",  framing_err_o, 64'h1);
        ack_pulse();
        step(4);

        // N = 1: start bit only, always a framing error.
        rxbaud_i = 16'd3;
        bits_i   = 6'd1;
        send_frame(64'h0, 1, 3);
        wait_done("n1", 1, 1'b0);
        check("n1_valid", rxvalid_o,     64'h1);
        check("n1_ferr",  framing_err_o, 64'h1);
        check("n1_dat",   dat_o,         64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
